// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: turns the 32-bit command word stream into validated,
// fully assembled commands on a ready/valid port. Malformed frames are
// drained word by word and reported with a one-cycle error pulse.
module cmd_frame_parser #(
    parameter int MAX_PAYLOAD_WORDS = 3,
    parameter bit STRICT_LEN        = 1'b1,
    parameter int ERR_CNT_WIDTH     = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            word_v_i,
    input  logic [31:0]                     word_i,
    output logic                            word_ready_o,
    output logic                            cmd_v_o,
    input  logic                            cmd_ready_i,
    output logic [7:0]                      cmd_op_o,
    output logic [7:0]                      cmd_id_o,
    output logic [32*MAX_PAYLOAD_WORDS-1:0] cmd_payload_o,
    output logic                            err_v_o,
    output logic [1:0]                      err_code_o,
    output logic [ERR_CNT_WIDTH-1:0]        err_cnt_o
);

    localparam int PW = 32 * MAX_PAYLOAD_WORDS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_DRAIN,
        S_EMIT,
        S_ERR
    } state_t;

    localparam logic [1:0] CODE_UNKNOWN_OP = 2'd1;
    localparam logic [1:0] CODE_BAD_LEN    = 2'd2;

    state_t state_q, state_d;

    logic [7:0]               op_q, id_q;
    logic [PW-1:0]            payload_q;
    logic [1:0]               cap_idx_q;   // next payload slot to fill
    logic [1:0]               cap_last_q;  // slot index of the last captured word
    logic [6:0]               drain_q;     // words still to discard
    logic                     bad_q;       // current frame ends in an error
    logic [1:0]               pend_code_q; // error code to report once drained
    logic [1:0]               err_code_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    // Header fields; bits [31:24] carry nothing for this block.
    logic [7:0] hdr_op, hdr_id, hdr_len;
    logic [6:0] hdr_words;
    logic       unused_hdr_bits;

    assign hdr_op          = word_i[7:0];
    assign hdr_id          = word_i[15:8];
    assign hdr_len         = word_i[23:16];
    assign unused_hdr_bits = ^word_i[31:24];
    // Words after the header: ceil(len/4), 0..64.
    assign hdr_words       = {1'b0, hdr_len[7:2]} + {6'd0, |hdr_len[1:0]};

    logic [7:0] exp_len;
    logic [1:0] exp_words;
    logic       op_known;
    logic       hdr_good;
    logic [1:0] hdr_code;

    // Look up the expected payload length and classify the incoming header.
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        exp_len  = 8'd0;
        op_known = 1'b1;
        case (hdr_op)
            8'hF0, 8'hF1, 8'hF2: exp_len = 8'd12;
            8'hF3, 8'hF4:        exp_len = 8'd4;
            8'hF5:               exp_len = 8'd8;
            default:             op_known = 1'b0;
        endcase
        exp_words = exp_len[3:2];

        hdr_good = op_known && (hdr_len[1:0] == 2'b00) && (hdr_len >= exp_len);
        if (STRICT_LEN && (hdr_len != exp_len)) begin
            hdr_good = 1'b0;
        end
        hdr_code = op_known ? CODE_BAD_LEN : CODE_UNKNOWN_OP;
    end

    logic accept;
    assign accept = word_v_i && word_ready_o;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d      = state_q;
        word_ready_o = 1'b0;
        cmd_v_o      = 1'b0;
        err_v_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                word_ready_o = 1'b1;
                if (accept) begin
                    if (hdr_good)               state_d = S_PAYLOAD;
                    else if (hdr_words == 7'd0) state_d = S_ERR;
                    else                        state_d = S_DRAIN;
                end
            end
            S_PAYLOAD: begin
                word_ready_o = 1'b1;
                if (accept && (cap_idx_q == cap_last_q)) begin
                    state_d = (drain_q != 7'd0) ? S_DRAIN : S_EMIT;
                end
            end
            S_DRAIN: begin
                word_ready_o = 1'b1;
                if (accept && (drain_q == 7'd1)) begin
                    state_d = bad_q ? S_ERR : S_EMIT;
                end
            end
            S_EMIT: begin
                cmd_v_o = 1'b1;
                if (cmd_ready_i) state_d = S_IDLE;
            end
            S_ERR: begin
                err_v_o = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath: latch header, capture payload, count drained words.
    // NOTE: the payload register is cleared by reset as well as per header,
    // because its value is visible on cmd_payload_o straight out of reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q        <= 8'd0;
            id_q        <= 8'd0;
            payload_q   <= '0;
            cap_idx_q   <= 2'd0;
            cap_last_q  <= 2'd0;
            drain_q     <= 7'd0;
            bad_q       <= 1'b0;
            pend_code_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= hdr_op;
                        id_q        <= hdr_id;
                        payload_q   <= '0;
                        cap_idx_q   <= 2'd0;
                        cap_last_q  <= exp_words - 2'd1;
                        bad_q       <= !hdr_good;
                        pend_code_q <= hdr_code;
                        drain_q     <= hdr_good ? (hdr_words - {5'd0, exp_words})
                                                : hdr_words;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        for (int k = 0; k < 3; k++) begin
                            if (cap_idx_q == 2'(k)) payload_q[32*k +: 32] <= word_i;
                        end
                        cap_idx_q <= cap_idx_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (accept) drain_q <= drain_q - 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Error reporting: code and saturating count update as ERR is entered,
    // so both are already current during the err_v_o pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_code_q <= 2'd0;
            err_cnt_q  <= '0;
        end else if (state_d == S_ERR) begin
            err_code_q <= (state_q == S_IDLE) ? hdr_code : pend_code_q;
            if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign cmd_op_o      = op_q;
    assign cmd_id_o      = id_q;
    assign cmd_payload_o = payload_q;
    assign err_code_o    = err_code_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
